vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA timing decoder: measures hsync/vsync against the nominal timing,
// locks after one clean frame and emits active-pixel coordinates and colour.
module vga_sync_decoder #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_VALID = 640,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_VALID = 480,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic       sys_clk,
  input  logic       sys_rstn,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] vga_rgb,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [2:0] pix_rgb,
  output logic       pix_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err,
  output logic [7:0] err_cnt
);

  localparam int unsigned HCW  = 11;
  localparam int unsigned VCW  = 10;
  localparam int unsigned PXW  = 10;
  localparam int unsigned RGBW = 3;
  localparam int unsigned ECW  = 8;

  localparam logic [HCW-1:0] H_MAX     = '1;
  localparam logic [VCW-1:0] V_MAX     = '1;
  localparam logic [ECW-1:0] E_MAX     = '1;
  localparam logic [HCW-1:0] H_LAST    = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_SYNC_W  = HCW'(H_SYNC);
  localparam logic [HCW-1:0] H_START   = HCW'(H_SYNC + H_BACK);
  localparam logic [HCW-1:0] H_END     = HCW'(H_SYNC + H_BACK + H_VALID);
  localparam logic [VCW-1:0] V_LAST    = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_START   = VCW'(V_SYNC + V_BACK);
  localparam logic [VCW-1:0] V_END     = VCW'(V_SYNC + V_BACK + V_VALID);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                bad_q, bad_d;
  logic                hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
  logic [RGBW-1:0]     rgb_s1_q, rgb_s2_q;
  logic [HCW-1:0]      h_cnt_q, h_cnt_d;
  logic [VCW-1:0]      v_cnt_q, v_cnt_d;
  logic                hs_rise, hs_fall, vs_rise;
  logic                line_bad, frame_bad, exit_err;
  logic                h_win, v_win;

  logic [PXW-1:0]      pix_x_q, pix_x_d;
  logic [PXW-1:0]      pix_y_q, pix_y_d;
  logic [RGBW-1:0]     pix_rgb_q, pix_rgb_d;
  logic                pix_valid_q, pix_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                locked_q, locked_d;
  logic                sync_err_q, sync_err_d;
  logic [ECW-1:0]      err_cnt_q, err_cnt_d;

  // Edge detect on the two-stage input pipeline.
  always_comb begin
    hs_rise = hs_s1_q & ~hs_s2_q;
    hs_fall = ~hs_s1_q & hs_s2_q;
    vs_rise = vs_s1_q & ~vs_s2_q;
  end

  // Current-cycle line/frame counters and timing error detection.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (hs_rise) begin
      h_cnt_d = '0;
    end else if (h_cnt_q != H_MAX) begin
      h_cnt_d = h_cnt_q + HCW'(1);
    end
    if (vs_rise) begin
      v_cnt_d = '0;
    end else if (hs_rise && (v_cnt_q != V_MAX)) begin
      v_cnt_d = v_cnt_q + VCW'(1);
    end
    line_bad  = (hs_rise && (h_cnt_q != H_LAST)) ||
                (hs_fall && (h_cnt_d != H_SYNC_W)) ||
                (h_cnt_d == H_MAX);
    frame_bad = vs_rise && (v_cnt_q != V_LAST);
  end

  // Input pipeline and counter registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      hs_s1_q  <= 1'b0;
      hs_s2_q  <= 1'b0;
      vs_s1_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
      rgb_s1_q <= '0;
      rgb_s2_q <= '0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
    end else begin
      hs_s1_q  <= hsync;
      hs_s2_q  <= hs_s1_q;
      vs_s1_q  <= vsync;
      vs_s2_q  <= vs_s1_q;
      rgb_s1_q <= vga_rgb;
      rgb_s2_q <= rgb_s1_q;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
    end
  end

  // FSM state register, including the bad-line accumulator of the frame under test.
  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      state_q <= SEARCH;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
    end
  end

  // FSM next state; each vs_rise starts a fresh frame measurement.
  always_comb begin
    state_d = state_q;
    bad_d   = bad_q;
    case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d = CHECK;
          bad_d   = 1'b0;
        end
      end
      CHECK: begin
        if (vs_rise) begin
          if (!(bad_q || line_bad || frame_bad)) begin
            state_d = LOCKED;
          end
          bad_d = 1'b0;
        end else begin
          bad_d = bad_q | line_bad;
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad) begin
          state_d = SEARCH;
        end
      end
      default: begin
        state_d = SEARCH;
        bad_d   = 1'b0;
      end
    endcase
  end

  // FSM outputs and pixel window decode, registered below.
  always_comb begin
    exit_err      = (state_q == LOCKED) && (state_d == SEARCH);
    locked_d      = (state_d == LOCKED);
    h_win         = (h_cnt_d >= H_START) && (h_cnt_d < H_END);
    v_win         = (v_cnt_d >= V_START) && (v_cnt_d < V_END);
    pix_valid_d   = locked_d && h_win && v_win;
    pix_x_d       = '0;
    pix_y_d       = '0;
    pix_rgb_d     = '0;
    if (pix_valid_d) begin
      pix_x_d   = PXW'(h_cnt_d - H_START);
      pix_y_d   = PXW'(v_cnt_d - V_START);
      pix_rgb_d = rgb_s2_q;
    end
    frame_start_d = vs_rise && (state_q == LOCKED) && (state_d == LOCKED);
    sync_err_d    = exit_err;
    err_cnt_d     = err_cnt_q;
    if (exit_err && (err_cnt_q != E_MAX)) begin
      err_cnt_d = err_cnt_q + ECW'(1);
    end
  end

  // Output registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a shrunken 10x6 timing.
module tb_vga_sync_decoder;

  localparam int TH_SYNC  = 2;
  localparam int TH_BACK  = 2;
  localparam int TH_VALID = 4;
  localparam int TH_TOTAL = 10;
  localparam int TV_SYNC  = 1;
  localparam int TV_BACK  = 1;
  localparam int TV_VALID = 3;
  localparam int TV_TOTAL = 6;
  localparam int FRAME_PIX = TH_VALID * TV_VALID;

  logic       sys_clk;
  logic       sys_rstn;
  logic       hsync;
  logic       vsync;
  logic [2:0] vga_rgb;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [2:0] pix_rgb;
  logic       pix_valid;
  logic       frame_start;
  logic       locked;
  logic       sync_err;
  logic [7:0] err_cnt;

  vga_sync_decoder #(
    .H_SYNC (TH_SYNC),  .H_BACK (TH_BACK),  .H_VALID(TH_VALID), .H_TOTAL(TH_TOTAL),
    .V_SYNC (TV_SYNC),  .V_BACK (TV_BACK),  .V_VALID(TV_VALID), .V_TOTAL(TV_TOTAL)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rstn   (sys_rstn),
    .hsync      (hsync),
    .vsync      (vsync),
    .vga_rgb    (vga_rgb),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .locked     (locked),
    .sync_err   (sync_err),
    .err_cnt    (err_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int lines;
    int bad_line;
    int bad_len;
    int exp_locked;
    int exp_valid;
    int exp_pulse;
    int exp_fs;
    int exp_err;
  } vec_t;

  vec_t vecs [11];

  int n_cmp = 0;
  int n_bad = 0;
  int m = 0;
  int hc_h [4];
  int hl_h [4];
  logic [2:0] rgb_h [4];
  int cnt_valid, cnt_err, cnt_fs;
  logic ob_locked, ob_valid, ob_fs, ob_serr;
  logic [9:0] ob_x, ob_y;
  logic [2:0] ob_rgb;
  logic [7:0] ob_ecnt;
  int exp_err;
  int first_err;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One pixel clock: observe outputs (reflecting the drive two calls back), then drive.
  task automatic drive(input logic h, input logic v, input int c, input int l, input logic rn);
    int pc, pl;
    logic [2:0] prgb, nrgb;
    logic win;
    @(negedge sys_clk);
    ob_locked = locked;  ob_valid = pix_valid; ob_fs = frame_start; ob_serr = sync_err;
    ob_x = pix_x; ob_y = pix_y; ob_rgb = pix_rgb; ob_ecnt = err_cnt;
    pc   = hc_h[(m - 2) & 3];
    pl   = hl_h[(m - 2) & 3];
    prgb = rgb_h[(m - 3) & 3];
    if (ob_valid) begin
      win = (pc >= TH_SYNC + TH_BACK) && (pc < TH_SYNC + TH_BACK + TH_VALID) &&
            (pl >= TV_SYNC + TV_BACK) && (pl < TV_SYNC + TV_BACK + TV_VALID);
      chk("valid_win", int'(win), 1);
      chk("valid_locked", int'(ob_locked), 1);
      chk("pix_x", int'(ob_x), pc - (TH_SYNC + TH_BACK));
      chk("pix_y", int'(ob_y), pl - (TV_SYNC + TV_BACK));
      chk("pix_rgb", int'(ob_rgb), int'(prgb));
      cnt_valid++;
    end else begin
      chk("idle_xyrgb", int'(ob_x) + int'(ob_y) + int'(ob_rgb), 0);
    end
    if (ob_serr) cnt_err++;
    if (ob_fs) cnt_fs++;
    nrgb     = 3'(m ^ (m >> 2));
    hsync    = h;
    vsync    = v;
    vga_rgb  = nrgb;
    sys_rstn = rn;
    hc_h[m & 3]  = c;
    hl_h[m & 3]  = l;
    rgb_h[m & 3] = nrgb;
    m++;
  endtask

  task automatic send_frame(input int lines, input int bad_line, input int bad_len);
    int len;
    cnt_valid = 0; cnt_err = 0; cnt_fs = 0;
    for (int l = 0; l < lines; l++) begin
      len = (l == bad_line) ? bad_len : TH_TOTAL;
      for (int c = 0; c < len; c++) begin
        drive(c < TH_SYNC, l < TV_SYNC, c, l, 1'b1);
      end
    end
  endtask

  initial begin
    // lines, bad_line, bad_len, locked, valid, pulses, frame_start, err_cnt
    vecs[0]  = '{6, -1, 0, 0, 0,         0, 0, 0};
    vecs[1]  = '{6, -1, 0, 1, FRAME_PIX, 0, 0, 0};
    vecs[2]  = '{6, -1, 0, 1, FRAME_PIX, 0, 1, 0};
    vecs[3]  = '{6,  2, 11, 0, TH_VALID, 1, 1, 1};
    vecs[4]  = '{6, -1, 0, 0, 0,         0, 0, 1};
    vecs[5]  = '{6, -1, 0, 1, FRAME_PIX, 0, 0, 1};
    vecs[6]  = '{5, -1, 0, 1, FRAME_PIX, 0, 1, 1};
    vecs[7]  = '{6, -1, 0, 0, 0,         1, 0, 2};
    vecs[8]  = '{5, -1, 0, 0, 0,         0, 0, 2};
    vecs[9]  = '{6, -1, 0, 0, 0,         0, 0, 2};
    vecs[10] = '{6, -1, 0, 1, FRAME_PIX, 0, 0, 2};

    for (int i = 0; i < 4; i++) begin
      hc_h[i] = 0; hl_h[i] = 0; rgb_h[i] = 3'd0;
    end
    sys_rstn = 1'b0; hsync = 1'b0; vsync = 1'b0; vga_rgb = 3'd0;

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, TH_TOTAL, TV_TOTAL, 1'b0);
    chk("rst_locked", int'(ob_locked), 0);
    chk("rst_valid", int'(ob_valid), 0);
    chk("rst_err_cnt", int'(ob_ecnt), 0);
    chk("rst_pulses", int'(ob_fs) + int'(ob_serr), 0);

    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i].lines, vecs[i].bad_line, vecs[i].bad_len);
      chk($sformatf("v%0d_locked", i), int'(ob_locked), vecs[i].exp_locked);
      chk($sformatf("v%0d_valid", i), cnt_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d_pulse", i), cnt_err, vecs[i].exp_pulse);
      chk($sformatf("v%0d_fs", i), cnt_fs, vecs[i].exp_fs);
      chk($sformatf("v%0d_err_cnt", i), int'(ob_ecnt), vecs[i].exp_err);
    end

    // hsync stuck low while locked: saturation of h_cnt is the error.
    cnt_err = 0;
    first_err = -1;
    for (int j = 0; j < 2100; j++) begin
      drive(1'b0, 1'b0, TH_TOTAL + j, TV_TOTAL - 1, 1'b1);
      if (j == 2038) chk("hold_locked_before", int'(ob_locked), 1);
      if (ob_serr && first_err < 0) first_err = j;
    end
    chk("hold_err_at", first_err, 2039);
    chk("hold_pulses", cnt_err, 1);
    chk("hold_err_cnt", int'(ob_ecnt), 3);
    chk("hold_locked", int'(ob_locked), 0);
    send_frame(TV_TOTAL, -1, 0);
    chk("hold_search", int'(ob_locked), 0);
    send_frame(TV_TOTAL, -1, 0);
    chk("hold_relock", int'(ob_locked), 1);

    // Repeated lock/error cycles to saturate err_cnt.
    exp_err = 3;
    for (int k = 0; k < 300; k++) begin
      send_frame(2, 0, TH_TOTAL + 1);
      chk("sat_pulse", cnt_err, 1);
      if (exp_err < 255) exp_err++;
      send_frame(TV_TOTAL, -1, 0);
      send_frame(TV_TOTAL, -1, 0);
      chk("sat_err_cnt", int'(ob_ecnt), exp_err);
    end
    chk("sat_locked", int'(ob_locked), 1);

    // One-clock reset in the middle of an active line.
    for (int l = 0; l < TV_TOTAL; l++) begin
      for (int c = 0; c < TH_TOTAL; c++) begin
        drive(c < TH_SYNC, l < TV_SYNC, c, l, !(l == 2 && c == 5));
        if (l == 2 && c == 6) begin
          chk("mrst_locked", int'(ob_locked), 0);
          chk("mrst_valid", int'(ob_valid), 0);
          chk("mrst_xyrgb", int'(ob_x) + int'(ob_y) + int'(ob_rgb), 0);
          chk("mrst_pulses", int'(ob_fs) + int'(ob_serr), 0);
          chk("mrst_err_cnt", int'(ob_ecnt), 0);
        end
      end
    end
    send_frame(TV_TOTAL, -1, 0);
    chk("mrst_check", int'(ob_locked), 0);
    send_frame(TV_TOTAL, -1, 0);
    chk("mrst_relock", int'(ob_locked), 1);
    chk("mrst_relock_valid", cnt_valid, FRAME_PIX);
    chk("mrst_relock_err", int'(ob_ecnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
